// File: rtl/draw_rect_ctrl.sv
// ============================================================================
// draw_rect_ctrl : sequences a line drawer to render outline or filled rects
// Revision 1.0
// ============================================================================
`default_nettype none

module draw_rect_ctrl #(
    parameter int RISE_TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] start_x_pos,
    input  logic [6:0] start_y_pos,
    input  logic [6:0] rect_width,
    input  logic [6:0] rect_height,
    input  logic       fill,
    input  logic       start_rect,
    input  logic       line_running,
    output logic       line_start,
    output logic [7:0] line_x_pos,
    output logic [6:0] line_y_pos,
    output logic [7:0] line_x_length,
    output logic [7:0] line_y_length,
    output logic       busy,
    output logic       done
);

    localparam int TW = $clog2(RISE_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_RISE = 3'd2,
        WAIT_FALL = 3'd3,
        NEXT      = 3'd4
    } state_t;

    state_t      state, state_next;
    logic [7:0]  rect_x;
    logic [6:0]  rect_y, rect_w, rect_h;
    logic        rect_fill;
    logic [6:0]  line_idx;
    logic [TW-1:0] rise_cnt;
    logic        load_geo;
    logic        last_line;

    // Geometry source: raw inputs for the first line, latched copy afterwards
    logic [7:0]  sel_x;
    logic [6:0]  sel_y, sel_w, sel_h, sel_k;
    logic        sel_fill;
    logic [7:0]  geo_x, geo_xl, geo_yl, x_plus_w;
    logic [6:0]  geo_y, y_plus_h, y_plus_k;

    assign last_line = rect_fill ? (line_idx == rect_h)
                     : ((rect_w == 7'd0) || (rect_h == 7'd0)) ? (line_idx == 7'd1)
                     : (line_idx == 7'd3);

    assign line_start = (state == ISSUE);
    assign done       = (state == NEXT) && last_line;
    assign busy       = (state != IDLE) && !done;

    always_comb begin
        state_next = state;
        load_geo   = 1'b0;
        case (state)
            IDLE: begin
                if (start_rect) begin
                    state_next = ISSUE;
                    load_geo   = 1'b1;
                end
            end
            ISSUE:     state_next = WAIT_RISE;
            WAIT_RISE: begin
                if (line_running)
                    state_next = WAIT_FALL;
                else if (rise_cnt == TW'(RISE_TIMEOUT - 1))
                    state_next = NEXT;
            end
            WAIT_FALL: begin
                if (!line_running)
                    state_next = NEXT;
            end
            NEXT: begin
                if (last_line) begin
                    state_next = IDLE;
                end else begin
                    state_next = ISSUE;
                    load_geo   = 1'b1;
                end
            end
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        sel_x    = (state == IDLE) ? start_x_pos : rect_x;
        sel_y    = (state == IDLE) ? start_y_pos : rect_y;
        sel_w    = (state == IDLE) ? rect_width  : rect_w;
        sel_h    = (state == IDLE) ? rect_height : rect_h;
        sel_fill = (state == IDLE) ? fill        : rect_fill;
        sel_k    = (state == IDLE) ? 7'd0        : line_idx + 7'd1;
        x_plus_w = sel_x + {1'b0, sel_w};
        y_plus_h = sel_y + sel_h;
        y_plus_k = sel_y + sel_k;
        geo_x    = sel_x;
        geo_y    = sel_y;
        geo_xl   = 8'd0;
        geo_yl   = 8'd0;
        if (sel_fill) begin
            geo_y  = y_plus_k;
            geo_xl = {1'b0, sel_w};
        end else begin
            // Negative lengths only carry the sign bit when the magnitude is nonzero
            case (sel_k[1:0])
                2'd0: geo_xl = {1'b0, sel_w};
                2'd1: begin
                    geo_x  = x_plus_w;
                    geo_yl = {1'b0, sel_h};
                end
                2'd2: begin
                    geo_x  = x_plus_w;
                    geo_y  = y_plus_h;
                    geo_xl = {|sel_w, sel_w};
                end
                default: begin
                    geo_y  = y_plus_h;
                    geo_yl = {|sel_h, sel_h};
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            rect_x        <= 8'd0;
            rect_y        <= 7'd0;
            rect_w        <= 7'd0;
            rect_h        <= 7'd0;
            rect_fill     <= 1'b0;
            line_idx      <= 7'd0;
            rise_cnt      <= '0;
            line_x_pos    <= 8'd0;
            line_y_pos    <= 7'd0;
            line_x_length <= 8'd0;
            line_y_length <= 8'd0;
        end else begin
            state <= state_next;
            if (state == IDLE && start_rect) begin
                rect_x    <= start_x_pos;
                rect_y    <= start_y_pos;
                rect_w    <= rect_width;
                rect_h    <= rect_height;
                rect_fill <= fill;
                line_idx  <= 7'd0;
            end else if (state == NEXT && !last_line) begin
                line_idx <= line_idx + 7'd1;
            end
            rise_cnt <= (state == WAIT_RISE) ? rise_cnt + TW'(1) : '0;
            if (load_geo) begin
                line_x_pos    <= geo_x;
                line_y_pos    <= geo_y;
                line_x_length <= geo_xl;
                line_y_length <= geo_yl;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_draw_rect_ctrl.sv
// ============================================================================
// tb_draw_rect_ctrl : randomized scoreboard bench for draw_rect_ctrl
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_draw_rect_ctrl;

    localparam int RISE_TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] start_x_pos = 8'd0;
    logic [6:0] start_y_pos = 7'd0;
    logic [6:0] rect_width = 7'd0;
    logic [6:0] rect_height = 7'd0;
    logic       fill = 1'b0;
    logic       start_rect = 1'b0;
    logic       line_running = 1'b0;
    logic       line_start;
    logic [7:0] line_x_pos;
    logic [6:0] line_y_pos;
    logic [7:0] line_x_length;
    logic [7:0] line_y_length;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    draw_rect_ctrl #(.RISE_TIMEOUT(RISE_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_x_pos(start_x_pos), .start_y_pos(start_y_pos),
        .rect_width(rect_width), .rect_height(rect_height),
        .fill(fill), .start_rect(start_rect), .line_running(line_running),
        .line_start(line_start), .line_x_pos(line_x_pos), .line_y_pos(line_y_pos),
        .line_x_length(line_x_length), .line_y_length(line_y_length),
        .busy(busy), .done(done)
    );

    typedef struct packed {
        logic       is_done;
        logic [7:0] x;
        logic [6:0] y;
        logic [7:0] xl;
        logic [7:0] yl;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   lines_seen = 0;
    bit   never_rise = 1'b0;
    bit   drawer_busy = 1'b0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endfunction

    function automatic void fail_msg(string name, logic [31:0] got);
        total++;
        bad++;
        $display("FAIL %s: got %h want none", name, got);
    endfunction

    // Signed-magnitude length: direction bit only when magnitude is nonzero
    function automatic logic [7:0] enc(bit neg, int mag);
        logic [6:0] m;
        m = 7'(mag);
        return {neg && (m != 7'd0), m};
    endfunction

    function automatic void push_line(int x, int y, logic [7:0] xl, logic [7:0] yl);
        exp_t e;
        e.is_done = 1'b0;
        e.x  = 8'(x % 256);
        e.y  = 7'(y % 128);
        e.xl = xl;
        e.yl = yl;
        q.push_back(e);
    endfunction

    function automatic void model_rect(int x, int y, int w, int h, bit f);
        exp_t d;
        if (f) begin
            for (int k = 0; k <= h; k++)
                push_line(x, y + k, enc(0, w), 8'd0);
        end else begin
            push_line(x, y, enc(0, w), 8'd0);
            push_line(x + w, y, 8'd0, enc(0, h));
            if (w != 0 && h != 0) begin
                push_line(x + w, y + h, enc(1, w), 8'd0);
                push_line(x, y + h, 8'd0, enc(1, h));
            end
        end
        d = '0;
        d.is_done = 1'b1;
        q.push_back(d);
    endfunction

    task automatic issue_rect(int x, int y, int w, int h, bit f);
        model_rect(x, y, w, h, f);
        @(posedge clk); #1;
        start_x_pos = 8'(x); start_y_pos = 7'(y);
        rect_width  = 7'(w); rect_height = 7'(h);
        fill = f; start_rect = 1'b1;
        @(posedge clk); #1;
        start_rect  = 1'b0;
        start_x_pos = 8'($urandom); start_y_pos = 7'($urandom);
        rect_width  = 7'($urandom); rect_height = 7'($urandom);
        fill = 1'($urandom);
        @(negedge clk);
        check("first_line_latency", 32'(line_start), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || drawer_busy) && n < 6000);
        check("idle_timeout", 32'(n >= 6000), 32'd0);
    endtask

    // Line drawer model: rises 1..3 cycles after line_start, busy 1..4 cycles
    initial begin : drawer
        int d, r;
        forever begin
            @(negedge clk);
            if (rst_n && line_start && !never_rise) begin
                drawer_busy = 1'b1;
                d = $urandom_range(1, 3);
                r = $urandom_range(1, 4);
                repeat (d) @(posedge clk);
                #1 line_running = 1'b1;
                repeat (r) @(posedge clk);
                #1 line_running = 1'b0;
                drawer_busy = 1'b0;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        logic [30:0] last_geo, cur_geo;
        last_geo = '0;
        forever begin
            @(negedge clk);
            cur_geo = {line_x_pos, line_y_pos, line_x_length, line_y_length};
            if (rst_n) begin
                if (line_start) begin
                    lines_seen++;
                    if (q.size() == 0) begin
                        fail_msg("unexpected_line", 32'(cur_geo));
                    end else begin
                        e = q.pop_front();
                        check("line_geom", {busy, e.is_done, 30'(cur_geo)},
                              {1'b1, 1'b0, 30'({e.x, e.y, e.xl, e.yl})});
                        check("line_x_msb", 32'(line_x_pos[7]), 32'(e.x[7]));
                    end
                    last_geo = cur_geo;
                end else if (busy) begin
                    check("hold_stable", 32'(cur_geo), 32'(last_geo));
                end
                if (done) begin
                    if (q.size() == 0 || !q[0].is_done) begin
                        fail_msg("unexpected_done", 32'(q.size()));
                    end else begin
                        void'(q.pop_front());
                        check("busy_in_done", 32'(busy), 32'd0);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int base, n;
        // Reset with a request held high: must be ignored
        start_rect = 1'b1; start_x_pos = 8'd33; rect_width = 7'd5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {line_start, busy, done, line_x_pos, line_y_pos,
                              line_x_length, line_y_length}, 32'd0);
        rst_n = 1'b1; start_rect = 1'b0;
        @(negedge clk);
        check("no_start_from_reset", {30'd0, line_start, busy}, 32'd0);

        issue_rect(10, 5, 20, 8, 1'b0);      // basic outline
        wait_idle();
        issue_rect(0, 0, 3, 2, 1'b1);        // small filled
        wait_idle();
        issue_rect(250, 120, 10, 10, 1'b0);  // coordinate wrap
        wait_idle();
        issue_rect(0, 0, 127, 127, 1'b1);    // 128 lines, full counter range
        wait_idle();

        never_rise = 1'b1;                   // drawer never answers: timeouts
        issue_rect(7, 9, 0, 0, 1'b0);
        wait_idle();
        issue_rect(100, 50, 0, 6, 1'b0);
        wait_idle();
        issue_rect(3, 3, 2, 3, 1'b1);
        wait_idle();
        never_rise = 1'b0;

        // Second request during WAIT_FALL of E0 must be ignored
        issue_rect(40, 20, 6, 4, 1'b0);
        n = 0;
        while (!line_running && n < 50) begin @(negedge clk); n++; end
        check("rise_wait", 32'(n >= 50), 32'd0);
        #1 start_x_pos = 8'd200; start_y_pos = 7'd99; rect_width = 7'd1;
        rect_height = 7'd1; fill = 1'b1; start_rect = 1'b1;
        @(posedge clk); #1 start_rect = 1'b0;
        wait_idle();

        // Reset during WAIT_FALL of E2 abandons the rectangle
        base = lines_seen;
        issue_rect(10, 5, 20, 8, 1'b0);
        n = 0;
        while (!(lines_seen == base + 3 && line_running) && n < 200) begin
            @(negedge clk); n++;
        end
        check("reach_e2_wait_fall", 32'(n >= 200), 32'd0);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("reset_mid", {line_start, busy, done, line_x_pos, line_y_pos,
                            line_x_length, line_y_length}, 32'd0);
        q.delete();
        rst_n = 1'b1;
        wait_idle();
        issue_rect(10, 5, 20, 8, 1'b0);
        wait_idle();

        for (int i = 0; i < 25; i++) begin
            bit f;
            f = 1'($urandom);
            never_rise = ($urandom_range(0, 4) == 0);
            issue_rect($urandom_range(0, 255), $urandom_range(0, 127),
                       $urandom_range(0, 127),
                       f ? $urandom_range(0, 15) : $urandom_range(0, 127), f);
            wait_idle();
        end
        never_rise = 1'b0;

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/draw_rect_ctrl.md
DRAW_RECT_CTRL -- requirements
Module: draw_rect_ctrl

Interface
REQ-001 Parameter: RISE_TIMEOUT, default 4, max cycles to wait for line_running to rise after a line_start pulse.
REQ-002 clk  in  1  single clock; all logic on its rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 start_x_pos  in  8  rectangle top-left x.
REQ-005 start_y_pos  in  7  rectangle top-left y.
REQ-006 rect_width  in  7  W, x extent in pixels minus one.
REQ-007 rect_height  in  7  H, y extent in pixels minus one.
REQ-008 fill  in  1  0 = outline, 1 = filled.
REQ-009 start_rect  in  1  one-cycle request; sampled only in IDLE.
REQ-010 line_running  in  1  busy flag from the line drawer.
REQ-011 line_start  out  1  one-cycle start pulse to the line drawer.
REQ-012 line_x_pos  out  8  line start x.
REQ-013 line_y_pos  out  7  line start y.
REQ-014 line_x_length  out  8  bit7 = direction (1 = negative), bits[6:0] = magnitude.
REQ-015 line_y_length  out  8  same format as line_x_length.
REQ-016 busy  out  1  high from acceptance until done.
REQ-017 done  out  1  one-cycle pulse when the rectangle completes.

Function
REQ-018 On acceptance, the controller shall latch all geometry and fill inputs; input changes while busy shall have no effect.
REQ-019 start_rect while busy shall be ignored, with no queuing.
REQ-020 States shall be IDLE, ISSUE, WAIT_RISE, WAIT_FALL, NEXT.
- IDLE -> ISSUE on start_rect.
- ISSUE -> WAIT_RISE unconditionally.
- WAIT_RISE -> WAIT_FALL when line_running = 1.
- WAIT_RISE -> NEXT after RISE_TIMEOUT cycles with line_running = 0.
- WAIT_FALL -> NEXT when line_running = 0.
- NEXT -> ISSUE if lines remain, else -> IDLE with done.
REQ-021 line_start shall be high only in ISSUE, for exactly one cycle per line; with start_rect high in cycle N, line_start shall be high in cycle N+1.
REQ-022 line_* position and length outputs shall be registered, valid in ISSUE, and held stable through WAIT_FALL.
REQ-023 Outline mode (fill = 0), clockwise order:
- E0: (x, y), x_len +W, y_len 0.
- E1: (x+W, y), x_len 0, y_len +H.
- E2: (x+W, y+H), x_len -W, y_len 0.
- E3: (x, y+H), x_len 0, y_len -H.
REQ-024 Outline with W = 0 or H = 0 shall issue only E0 and E1.
REQ-025 Filled mode (fill = 1) shall issue H+1 lines, line k (0..H) at (x, y+k) with x_len +W and y_len 0, in increasing k.
REQ-026 Coordinate sums shall wrap: x+W modulo 256, y+H and y+k modulo 128; no clipping is performed.
REQ-027 Zero magnitude shall always be encoded with direction bit 0.
REQ-028 done shall be high for one cycle in the NEXT->IDLE transition cycle, and busy shall be low in that same cycle.
REQ-029 The line counter shall be 7 bits and shall not overflow at H = 127 (128 lines).

Reset
REQ-030 While rst_n = 0 at a clock edge: state shall go to IDLE, line_start/busy/done shall be 0, and line_* outputs shall be 0.
REQ-031 Reset mid-operation shall abandon the rectangle with no done pulse; the line drawer is not reset by this block.
REQ-032 start_rect in the same cycle as rst_n = 0 shall be ignored.

Verification
REQ-033 Outline: x=10, y=5, W=20, H=8, fill=0 -> four line_start pulses:
- (10,5) x+20 y0
- (30,5) x0 y+8
- (30,13) x-20 y0
- (10,13) x0 y-8
- then one done pulse.
REQ-034 Filled: x=0, y=0, W=3, H=2, fill=1 -> three lines at y=0,1,2, each x_len 0x03 and y_len 0x00; done follows the last line_running fall.
REQ-035 Degenerate: W=0, H=0 -> only E0 (0 length) and E1 issued; with a drawer model that never raises line_running, each line advances after RISE_TIMEOUT cycles and done is still produced.
REQ-036 Busy ignore: a second start_rect with different geometry during WAIT_FALL -> no extra lines; output geometry stays that of the first request.
REQ-037 Wrap: x=250, y=120, W=10, H=10, outline -> E1 start x = 4, E2 start y = 2.
REQ-038 Reset in WAIT_FALL of E2 -> outputs zero on the next edge, no done pulse; a subsequent start_rect starts cleanly at E0.
